// File: rtl/pair_swap_stage.sv
// Two-word collect/exchange stage: gathers a pair into A/B, optionally swaps
// them on the second-word edge, then emits A then B over valid/ready.
module pair_swap_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             swap_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_first,
    output logic [CNT_W-1:0] swap_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONE   = 2'd1,
        EMIT1 = 2'd2,
        EMIT2 = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] reg_a, reg_b;
    logic             ld_first, ld_second, do_swap;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_first = 1'b0;
        out_data  = '0;
        ld_first  = 1'b0;
        ld_second = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_first = 1'b1;
                    state_nx = ONE;
                end
            end
            ONE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_second = 1'b1;
                    state_nx  = EMIT1;
                end
            end
            EMIT1: begin
                out_valid = 1'b1;
                out_first = 1'b1;
                out_data  = reg_a;
                if (out_ready) state_nx = EMIT2;
            end
            EMIT2: begin
                out_valid = 1'b1;
                out_data  = reg_b;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign do_swap = ld_second & swap_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Both registers sample pre-edge values, so the exchange is order-independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a <= '0;
            reg_b <= '0;
        end else if (ld_first) begin
            reg_a <= in_data;
        end else if (do_swap) begin
            reg_a <= in_data;
            reg_b <= reg_a;
        end else if (ld_second) begin
            reg_b <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       swap_cnt <= '0;
        else if (do_swap) swap_cnt <= swap_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pair_swap_stage.sv
// Self-checking bench for pair_swap_stage: directed table, stall, wrap,
// async reset and randomized pairs against a pair-level reference model.
module tb_pair_swap_stage;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             swap_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_first;
    logic [CNT_W-1:0] swap_cnt;

    pair_swap_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .swap_en(swap_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .swap_cnt(swap_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    typedef struct {
        logic [WIDTH-1:0] a;
        logic             sw_a;
        logic [WIDTH-1:0] b;
        logic             sw_b;
        logic [WIDTH-1:0] e0;
        logic [WIDTH-1:0] e1;
    } vec_t;

    vec_t vecs[4];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic s);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        swap_en  = s;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        swap_en  = 1'b0;
    endtask

    task automatic pull(output logic [WIDTH-1:0] d, output logic f, input int dly);
        int n = 0;
        repeat (dly) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("pull_timeout", {31'd0, out_valid}, 32'd1);
        d = out_data;
        f = out_first;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Reference: a pair {a,b} emits (swap ? b,a : a,b); each swapped pair bumps the count.
    task automatic run_pair(input string nm, input logic [WIDTH-1:0] a, input logic sw_a,
                            input logic [WIDTH-1:0] b, input logic sw_b, input int dly);
        logic [WIDTH-1:0] d0, d1, e0, e1;
        logic             f0, f1;
        e0 = sw_b ? b : a;
        e1 = sw_b ? a : b;
        if (sw_b) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        push(a, sw_a);
        push(b, sw_b);
        pull(d0, f0, dly);
        pull(d1, f1, dly);
        chk({nm, "_w0"}, {24'd0, d0}, {24'd0, e0});
        chk({nm, "_f0"}, {31'd0, f0}, 32'd1);
        chk({nm, "_w1"}, {24'd0, d1}, {24'd0, e1});
        chk({nm, "_f1"}, {31'd0, f1}, 32'd0);
        chk({nm, "_cnt"}, {24'd0, swap_cnt}, exp_cnt[31:0]);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic             f;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        vecs[0] = '{a: 8'h11, sw_a: 1'b0, b: 8'h22, sw_b: 1'b0, e0: 8'h11, e1: 8'h22};
        vecs[1] = '{a: 8'hA5, sw_a: 1'b0, b: 8'h3C, sw_b: 1'b1, e0: 8'h3C, e1: 8'hA5};
        vecs[2] = '{a: 8'h10, sw_a: 1'b1, b: 8'h20, sw_b: 1'b0, e0: 8'h10, e1: 8'h20};
        vecs[3] = '{a: 8'hFF, sw_a: 1'b1, b: 8'h00, sw_b: 1'b1, e0: 8'h00, e1: 8'hFF};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        swap_en   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_first", {31'd0, out_first}, 32'd0);
        chk("rst_swap_cnt", {24'd0, swap_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            push(vecs[i].a, vecs[i].sw_a);
            push(vecs[i].b, vecs[i].sw_b);
            if (vecs[i].sw_b) exp_cnt++;
            pull(d, f, 0);
            chk($sformatf("vec%0d_w0", i), {24'd0, d}, {24'd0, vecs[i].e0});
            chk($sformatf("vec%0d_f0", i), {31'd0, f}, 32'd1);
            pull(d, f, 0);
            chk($sformatf("vec%0d_w1", i), {24'd0, d}, {24'd0, vecs[i].e1});
            chk($sformatf("vec%0d_f1", i), {31'd0, f}, 32'd0);
            chk($sformatf("vec%0d_cnt", i), {24'd0, swap_cnt}, exp_cnt[31:0]);
        end

        // Output stall with ignored input and swap_en pulses
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_data  = 8'hEE;
            swap_en  = 1'b1;
            #1;
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_data", {24'd0, out_data}, 32'h01);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        swap_en  = 1'b0;
        pull(d, f, 0);
        chk("stall_w0", {24'd0, d}, 32'h01);
        pull(d, f, 0);
        chk("stall_w1", {24'd0, d}, 32'h02);
        chk("stall_cnt", {24'd0, swap_cnt}, exp_cnt[31:0]);

        // Counter wrap over 256 swapped pairs
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            run_pair("wrap", ra, 1'b0, rb, 1'b1, 0);
            if (i == 255) chk("wrap_255", {24'd0, swap_cnt}, 32'd255);
            if (i == 256) chk("wrap_256", {24'd0, swap_cnt}, 32'd0);
        end

        // Async reset between edges while in EMIT1
        push(8'h77, 1'b1);
        push(8'h88, 1'b1);
        exp_cnt++;
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", {24'd0, out_data}, 32'd0);
        chk("arst_swap_cnt", {24'd0, swap_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        run_pair("post_rst", 8'h55, 1'b0, 8'h66, 1'b0, 0);

        // Randomized pairs with random downstream stalls
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom_range(0, 1));
            run_pair("rand", ra, 1'($urandom_range(0, 1)), rb, rs, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
